// File: rtl/ddr_axi_arb_pkg.sv
// Shared types and defaults for the two-master DDR AXI4 arbiter.
package ddr_axi_arb_pkg;
  localparam int DEF_ID_W   = 5;
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;
  localparam logic [63:0] DEF_M0_MASK = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DEF_M1_MASK = 64'h0000_0000_FFFF_FFFF;

  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker; pointer remembers the last master served.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_upd_gnt,
  output logic       o_gnt
);
  logic r_last;

  // Reset to "master 1 served last" so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)        r_last <= 1'b1;
    else if (i_upd) r_last <= i_upd_gnt;
  end

  assign o_gnt = (i_req == 2'b11) ? ~r_last : i_req[1];
endmodule

// File: rtl/ddr_axi_arb.sv
// Shares one DDR AXI4 slave between two masters; read and write arbitrated independently.
module ddr_axi_arb
  import ddr_axi_arb_pkg::*;
#(
  parameter int ID_W = DEF_ID_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] M0_ADDR_MASK = DEF_M0_MASK,
  parameter logic [ADDR_W-1:0] M1_ADDR_MASK = DEF_M1_MASK
) (
  input  logic clk, rst,
  input  logic s0_awvalid, input logic [ID_W-1:0] s0_awid, input logic [ADDR_W-1:0] s0_awaddr,
  input  logic [7:0] s0_awlen, input logic [2:0] s0_awsize, input logic [1:0] s0_awburst, input logic s0_awlock,
  input  logic [3:0] s0_awcache, input logic [2:0] s0_awprot, input logic [3:0] s0_awqos, output logic s0_awready,
  input  logic s0_wvalid, input logic [DATA_W-1:0] s0_wdata, input logic [DATA_W/8-1:0] s0_wstrb,
  input  logic s0_wlast, output logic s0_wready,
  output logic s0_bvalid, output logic [ID_W-1:0] s0_bid, output logic [1:0] s0_bresp, input logic s0_bready,
  input  logic s0_arvalid, input logic [ID_W-1:0] s0_arid, input logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0] s0_arlen, input logic [2:0] s0_arsize, input logic [1:0] s0_arburst, input logic s0_arlock,
  input  logic [3:0] s0_arcache, input logic [2:0] s0_arprot, input logic [3:0] s0_arqos, output logic s0_arready,
  output logic s0_rvalid, output logic [ID_W-1:0] s0_rid, output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0] s0_rresp, output logic s0_rlast, input logic s0_rready,
  input  logic s1_awvalid, input logic [ID_W-1:0] s1_awid, input logic [ADDR_W-1:0] s1_awaddr,
  input  logic [7:0] s1_awlen, input logic [2:0] s1_awsize, input logic [1:0] s1_awburst, input logic s1_awlock,
  input  logic [3:0] s1_awcache, input logic [2:0] s1_awprot, input logic [3:0] s1_awqos, output logic s1_awready,
  input  logic s1_wvalid, input logic [DATA_W-1:0] s1_wdata, input logic [DATA_W/8-1:0] s1_wstrb,
  input  logic s1_wlast, output logic s1_wready,
  output logic s1_bvalid, output logic [ID_W-1:0] s1_bid, output logic [1:0] s1_bresp, input logic s1_bready,
  input  logic s1_arvalid, input logic [ID_W-1:0] s1_arid, input logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0] s1_arlen, input logic [2:0] s1_arsize, input logic [1:0] s1_arburst, input logic s1_arlock,
  input  logic [3:0] s1_arcache, input logic [2:0] s1_arprot, input logic [3:0] s1_arqos, output logic s1_arready,
  output logic s1_rvalid, output logic [ID_W-1:0] s1_rid, output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0] s1_rresp, output logic s1_rlast, input logic s1_rready,
  output logic m_awvalid, output logic [ID_W-1:0] m_awid, output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0] m_awlen, output logic [2:0] m_awsize, output logic [1:0] m_awburst, output logic m_awlock,
  output logic [3:0] m_awcache, output logic [2:0] m_awprot, output logic [3:0] m_awqos,
  output logic [3:0] m_awregion, input logic m_awready,
  output logic m_wvalid, output logic [DATA_W-1:0] m_wdata, output logic [DATA_W/8-1:0] m_wstrb,
  output logic m_wlast, input logic m_wready,
  input  logic m_bvalid, input logic [ID_W-1:0] m_bid, input logic [1:0] m_bresp, output logic m_bready,
  output logic m_arvalid, output logic [ID_W-1:0] m_arid, output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0] m_arlen, output logic [2:0] m_arsize, output logic [1:0] m_arburst, output logic m_arlock,
  output logic [3:0] m_arcache, output logic [2:0] m_arprot, output logic [3:0] m_arqos,
  output logic [3:0] m_arregion, input logic m_arready,
  input  logic m_rvalid, input logic [ID_W-1:0] m_rid, input logic [DATA_W-1:0] m_rdata,
  input  logic [1:0] m_rresp, input logic m_rlast, output logic m_rready
);
  wr_state_t r_wst;
  rd_state_t r_rst;
  logic      r_wgnt, r_rgnt;
  logic      w_wpick, w_rpick, w_wdone, w_rdone;

  assign w_wdone = (r_wst == WR_RESP) && m_bvalid && m_bready;
  assign w_rdone = (r_rst == RD_DATA) && m_rvalid && m_rready && m_rlast;

  rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .i_req({s1_awvalid, s0_awvalid}), .i_upd(w_wdone),
                    .i_upd_gnt(r_wgnt), .o_gnt(w_wpick));
  rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .i_req({s1_arvalid, s0_arvalid}), .i_upd(w_rdone),
                    .i_upd_gnt(r_rgnt), .o_gnt(w_rpick));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wst <= WR_IDLE; r_wgnt <= 1'b0;
    end else begin
      case (r_wst)
        WR_IDLE: if (s0_awvalid || s1_awvalid) begin r_wgnt <= w_wpick; r_wst <= WR_ADDR; end
        WR_ADDR: if (m_awvalid && m_awready) r_wst <= WR_DATA;
        WR_DATA: if (m_wvalid && m_wready && m_wlast) r_wst <= WR_RESP;
        WR_RESP: if (w_wdone) r_wst <= WR_IDLE;
        default: r_wst <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst <= RD_IDLE; r_rgnt <= 1'b0;
    end else begin
      case (r_rst)
        RD_IDLE: if (s0_arvalid || s1_arvalid) begin r_rgnt <= w_rpick; r_rst <= RD_ADDR; end
        RD_ADDR: if (m_arvalid && m_arready) r_rst <= RD_DATA;
        RD_DATA: if (w_rdone) r_rst <= RD_IDLE;
        default: r_rst <= RD_IDLE;
      endcase
    end
  end

  // Request muxes drive zero payload outside their phase so idle DDR-side buses stay quiet.
  always_comb begin
    {m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst} = '0;
    {m_awlock, m_awcache, m_awprot, m_awqos} = '0;
    if (r_wst == WR_ADDR) begin
      if (r_wgnt) begin
        {m_awvalid, m_awid, m_awaddr} = {s1_awvalid, s1_awid, s1_awaddr & M1_ADDR_MASK};
        {m_awlen, m_awsize, m_awburst} = {s1_awlen, s1_awsize, s1_awburst};
        {m_awlock, m_awcache, m_awprot, m_awqos} = {s1_awlock, s1_awcache, s1_awprot, s1_awqos};
      end else begin
        {m_awvalid, m_awid, m_awaddr} = {s0_awvalid, s0_awid, s0_awaddr & M0_ADDR_MASK};
        {m_awlen, m_awsize, m_awburst} = {s0_awlen, s0_awsize, s0_awburst};
        {m_awlock, m_awcache, m_awprot, m_awqos} = {s0_awlock, s0_awcache, s0_awprot, s0_awqos};
      end
    end
  end

  always_comb begin
    {m_wvalid, m_wdata, m_wstrb, m_wlast} = '0;
    if (r_wst == WR_DATA) begin
      if (r_wgnt) {m_wvalid, m_wdata, m_wstrb, m_wlast} = {s1_wvalid, s1_wdata, s1_wstrb, s1_wlast};
      else        {m_wvalid, m_wdata, m_wstrb, m_wlast} = {s0_wvalid, s0_wdata, s0_wstrb, s0_wlast};
    end
  end

  always_comb begin
    {m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst} = '0;
    {m_arlock, m_arcache, m_arprot, m_arqos} = '0;
    if (r_rst == RD_ADDR) begin
      if (r_rgnt) begin
        {m_arvalid, m_arid, m_araddr} = {s1_arvalid, s1_arid, s1_araddr & M1_ADDR_MASK};
        {m_arlen, m_arsize, m_arburst} = {s1_arlen, s1_arsize, s1_arburst};
        {m_arlock, m_arcache, m_arprot, m_arqos} = {s1_arlock, s1_arcache, s1_arprot, s1_arqos};
      end else begin
        {m_arvalid, m_arid, m_araddr} = {s0_arvalid, s0_arid, s0_araddr & M0_ADDR_MASK};
        {m_arlen, m_arsize, m_arburst} = {s0_arlen, s0_arsize, s0_arburst};
        {m_arlock, m_arcache, m_arprot, m_arqos} = {s0_arlock, s0_arcache, s0_arprot, s0_arqos};
      end
    end
  end

  assign m_awregion = 4'd0;
  assign m_arregion = 4'd0;

  assign s0_awready = (r_wst == WR_ADDR) && !r_wgnt && m_awready;
  assign s1_awready = (r_wst == WR_ADDR) &&  r_wgnt && m_awready;
  assign s0_wready  = (r_wst == WR_DATA) && !r_wgnt && m_wready;
  assign s1_wready  = (r_wst == WR_DATA) &&  r_wgnt && m_wready;
  assign s0_bvalid  = (r_wst == WR_RESP) && !r_wgnt && m_bvalid;
  assign s1_bvalid  = (r_wst == WR_RESP) &&  r_wgnt && m_bvalid;
  assign m_bready   = (r_wst == WR_RESP) && (r_wgnt ? s1_bready : s0_bready);
  assign {s0_bid, s0_bresp} = {m_bid, m_bresp};
  assign {s1_bid, s1_bresp} = {m_bid, m_bresp};

  assign s0_arready = (r_rst == RD_ADDR) && !r_rgnt && m_arready;
  assign s1_arready = (r_rst == RD_ADDR) &&  r_rgnt && m_arready;
  assign s0_rvalid  = (r_rst == RD_DATA) && !r_rgnt && m_rvalid;
  assign s1_rvalid  = (r_rst == RD_DATA) &&  r_rgnt && m_rvalid;
  assign m_rready   = (r_rst == RD_DATA) && (r_rgnt ? s1_rready : s0_rready);
  assign {s0_rid, s0_rdata, s0_rresp, s0_rlast} = {m_rid, m_rdata, m_rresp, m_rlast};
  assign {s1_rid, s1_rdata, s1_rresp, s1_rlast} = {m_rid, m_rdata, m_rresp, m_rlast};
endmodule

// File: tb/tb_ddr_axi_arb.sv
// Directed bench for ddr_axi_arb: routing, masking, round-robin, stalls, reset.
module tb_ddr_axi_arb;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  logic s0_awvalid, s0_awlock, s0_awready, s0_wvalid, s0_wlast, s0_wready, s0_bvalid, s0_bready;
  logic s0_arvalid, s0_arlock, s0_arready, s0_rvalid, s0_rlast, s0_rready;
  logic s1_awvalid, s1_awlock, s1_awready, s1_wvalid, s1_wlast, s1_wready, s1_bvalid, s1_bready;
  logic s1_arvalid, s1_arlock, s1_arready, s1_rvalid, s1_rlast, s1_rready;
  logic m_awvalid, m_awlock, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arlock, m_arready, m_rvalid, m_rlast, m_rready;
  logic [4:0]  s0_awid, s0_bid, s0_arid, s0_rid, s1_awid, s1_bid, s1_arid, s1_rid, m_awid, m_bid, m_arid, m_rid;
  logic [63:0] s0_awaddr, s0_araddr, s0_wdata, s0_rdata, s1_awaddr, s1_araddr, s1_wdata, s1_rdata;
  logic [63:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [7:0]  s0_awlen, s0_arlen, s0_wstrb, s1_awlen, s1_arlen, s1_wstrb, m_awlen, m_arlen, m_wstrb;
  logic [2:0]  s0_awsize, s0_awprot, s0_arsize, s0_arprot, s1_awsize, s1_awprot, s1_arsize, s1_arprot;
  logic [2:0]  m_awsize, m_awprot, m_arsize, m_arprot;
  logic [1:0]  s0_awburst, s0_bresp, s0_arburst, s0_rresp, s1_awburst, s1_bresp, s1_arburst, s1_rresp;
  logic [1:0]  m_awburst, m_bresp, m_arburst, m_rresp;
  logic [3:0]  s0_awcache, s0_awqos, s0_arcache, s0_arqos, s1_awcache, s1_awqos, s1_arcache, s1_arqos;
  logic [3:0]  m_awcache, m_awqos, m_arcache, m_arqos, m_awregion, m_arregion;

  int tests = 0, fails = 0;

  ddr_axi_arb dut (
    .clk(clk), .rst(rst),
    .s0_awvalid(s0_awvalid), .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
    .s0_awburst(s0_awburst), .s0_awlock(s0_awlock), .s0_awcache(s0_awcache), .s0_awprot(s0_awprot),
    .s0_awqos(s0_awqos), .s0_awready(s0_awready), .s0_wvalid(s0_wvalid), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_wlast(s0_wlast), .s0_wready(s0_wready), .s0_bvalid(s0_bvalid), .s0_bid(s0_bid), .s0_bresp(s0_bresp),
    .s0_bready(s0_bready), .s0_arvalid(s0_arvalid), .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
    .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arlock(s0_arlock), .s0_arcache(s0_arcache),
    .s0_arprot(s0_arprot), .s0_arqos(s0_arqos), .s0_arready(s0_arready), .s0_rvalid(s0_rvalid), .s0_rid(s0_rid),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rready(s0_rready),
    .s1_awvalid(s1_awvalid), .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
    .s1_awburst(s1_awburst), .s1_awlock(s1_awlock), .s1_awcache(s1_awcache), .s1_awprot(s1_awprot),
    .s1_awqos(s1_awqos), .s1_awready(s1_awready), .s1_wvalid(s1_wvalid), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_wlast(s1_wlast), .s1_wready(s1_wready), .s1_bvalid(s1_bvalid), .s1_bid(s1_bid), .s1_bresp(s1_bresp),
    .s1_bready(s1_bready), .s1_arvalid(s1_arvalid), .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
    .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arlock(s1_arlock), .s1_arcache(s1_arcache),
    .s1_arprot(s1_arprot), .s1_arqos(s1_arqos), .s1_arready(s1_arready), .s1_rvalid(s1_rvalid), .s1_rid(s1_rid),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rready(s1_rready),
    .m_awvalid(m_awvalid), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awqos(m_awqos),
    .m_awregion(m_awregion), .m_awready(m_awready), .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bid(m_bid), .m_bresp(m_bresp),
    .m_bready(m_bready), .m_arvalid(m_arvalid), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arqos(m_arqos), .m_arregion(m_arregion), .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rid(m_rid),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rready(m_rready)
  );

  task tick; @(posedge clk); #1; endtask

  task clear_inputs;
    {s0_awvalid, s0_awid, s0_awaddr, s0_awlen, s0_awsize, s0_awburst, s0_awlock, s0_awcache, s0_awprot, s0_awqos} = '0;
    {s1_awvalid, s1_awid, s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awlock, s1_awcache, s1_awprot, s1_awqos} = '0;
    {s0_arvalid, s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arlock, s0_arcache, s0_arprot, s0_arqos} = '0;
    {s1_arvalid, s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arlock, s1_arcache, s1_arprot, s1_arqos} = '0;
    {s0_wvalid, s0_wdata, s0_wstrb, s0_wlast, s0_bready, s0_rready} = '0;
    {s1_wvalid, s1_wdata, s1_wstrb, s1_wlast, s1_bready, s1_rready} = '0;
    {m_awready, m_wready, m_bvalid, m_bid, m_bresp, m_arready} = '0;
    {m_rvalid, m_rid, m_rdata, m_rresp, m_rlast} = '0;
  endtask

  task test_reset;
    clear_inputs(); rst = 1'b1;
    s0_awvalid = 1'b1; s1_arvalid = 1'b1; m_awready = 1'b1; m_arready = 1'b1; m_bvalid = 1'b1; m_rvalid = 1'b1;
    tick(); tick(); #1;
    tests++; if (m_awvalid !== 1'b0) begin fails++; $display("FAIL rst_m_awvalid got=%0h exp=0", m_awvalid); end
    tests++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL rst_m_arvalid got=%0h exp=0", m_arvalid); end
    tests++; if (m_wvalid !== 1'b0) begin fails++; $display("FAIL rst_m_wvalid got=%0h exp=0", m_wvalid); end
    tests++; if (m_bready !== 1'b0 || m_rready !== 1'b0) begin fails++; $display("FAIL rst_m_ready got=%0h/%0h exp=0/0", m_bready, m_rready); end
    tests++; if (s0_awready !== 1'b0 || s1_arready !== 1'b0) begin fails++; $display("FAIL rst_s_ready got=%0h/%0h exp=0/0", s0_awready, s1_arready); end
    tests++; if (s0_bvalid !== 1'b0 || s1_rvalid !== 1'b0) begin fails++; $display("FAIL rst_s_valid got=%0h/%0h exp=0/0", s0_bvalid, s1_rvalid); end
    tests++; if (m_awaddr !== 64'h0 || m_araddr !== 64'h0 || m_awregion !== 4'h0) begin fails++; $display("FAIL rst_payload got=%h/%h/%h exp=0", m_awaddr, m_araddr, m_awregion); end
    clear_inputs(); rst = 1'b0; tick();
  endtask

  task test_write_m1;
    s1_awvalid = 1'b1; s1_awid = 5'h03; s1_awaddr = 64'h1234_0000_8000_0000; s1_awlen = 8'd3;
    s1_awsize = 3'd3; s1_awburst = 2'b01; s1_awqos = 4'h5;
    s1_wvalid = 1'b1; s1_wdata = 64'hD0; s1_wstrb = 8'hFF; m_wready = 1'b1;
    #1;
    tests++; if (m_awvalid !== 1'b0) begin fails++; $display("FAIL wr1_idle_awvalid got=%0h exp=0", m_awvalid); end
    tick(); #1;
    tests++; if (m_awvalid !== 1'b1) begin fails++; $display("FAIL wr1_awvalid got=%0h exp=1", m_awvalid); end
    tests++; if (m_awaddr !== 64'h0000_0000_8000_0000) begin fails++; $display("FAIL wr1_mask got=%h exp=0000000080000000", m_awaddr); end
    tests++; if (m_awlen !== 8'd3 || m_awid !== 5'h03 || m_awburst !== 2'b01 || m_awqos !== 4'h5) begin fails++; $display("FAIL wr1_fields got=%0h/%0h/%0h/%0h exp=3/3/1/5", m_awlen, m_awid, m_awburst, m_awqos); end
    tests++; if (s1_awready !== 1'b0) begin fails++; $display("FAIL wr1_awready_wait got=%0h exp=0", s1_awready); end
    tests++; if (m_wvalid !== 1'b0) begin fails++; $display("FAIL wr1_w_before_aw got=%0h exp=0", m_wvalid); end
    m_awready = 1'b1; #1;
    tests++; if (s1_awready !== 1'b1 || s0_awready !== 1'b0) begin fails++; $display("FAIL wr1_awready got=%0h/%0h exp=1/0", s1_awready, s0_awready); end
    tick();
    s1_awvalid = 1'b0; m_awready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      s1_wdata = 64'hD0 + 64'(b); s1_wlast = (b == 3);
      #1;
      tests++; if (m_wvalid !== 1'b1 || m_wdata !== 64'hD0 + 64'(b) || m_wlast !== (b == 3)) begin fails++; $display("FAIL wr1_beat%0d got=%0h/%h/%0h exp=1/%h/%0h", b, m_wvalid, m_wdata, m_wlast, 64'hD0 + 64'(b), (b == 3)); end
      tests++; if (s1_wready !== 1'b1 || s0_wready !== 1'b0) begin fails++; $display("FAIL wr1_wready%0d got=%0h/%0h exp=1/0", b, s1_wready, s0_wready); end
      tick();
    end
    s1_wdata = 64'hDD; s1_wlast = 1'b0;
    m_bvalid = 1'b1; m_bid = 5'h03; m_bresp = 2'b00; s1_bready = 1'b1; s0_bready = 1'b1;
    #1;
    tests++; if (m_wvalid !== 1'b0 || s1_wready !== 1'b0) begin fails++; $display("FAIL wr1_extra_beat got=%0h/%0h exp=0/0", m_wvalid, s1_wready); end
    tests++; if (s1_bvalid !== 1'b1 || s0_bvalid !== 1'b0 || s1_bid !== 5'h03) begin fails++; $display("FAIL wr1_b_route got=%0h/%0h/%0h exp=1/0/3", s1_bvalid, s0_bvalid, s1_bid); end
    tests++; if (m_bready !== 1'b1) begin fails++; $display("FAIL wr1_bready got=%0h exp=1", m_bready); end
    tick(); clear_inputs(); #1;
    tests++; if (m_awvalid !== 1'b0 || m_bready !== 1'b0) begin fails++; $display("FAIL wr1_back_idle got=%0h/%0h exp=0/0", m_awvalid, m_bready); end
  endtask

  task test_read_rr;
    s0_arvalid = 1'b1; s0_arid = 5'h01; s0_araddr = 64'hAAAA_0000_0000_1000; s0_arlen = 8'd2;
    s1_arvalid = 1'b1; s1_arid = 5'h02; s1_araddr = 64'hBBBB_0000_0000_2000; s1_arlen = 8'd0;
    m_arready = 1'b1; #1;
    tests++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL rd_idle_arvalid got=%0h exp=0", m_arvalid); end
    tick(); #1;
    tests++; if (m_arvalid !== 1'b1 || m_arid !== 5'h01 || m_araddr !== 64'hAAAA_0000_0000_1000) begin fails++; $display("FAIL rd_grant0 got=%0h/%0h/%h exp=1/1/aaaa000000001000", m_arvalid, m_arid, m_araddr); end
    tests++; if (s0_arready !== 1'b1 || s1_arready !== 1'b0 || m_arlen !== 8'd2) begin fails++; $display("FAIL rd_arready0 got=%0h/%0h/%0h exp=1/0/2", s0_arready, s1_arready, m_arlen); end
    tick();
    s0_arvalid = 1'b0; s0_rready = 1'b1; m_rvalid = 1'b1; m_rid = 5'h01;
    for (int b = 0; b < 3; b++) begin
      m_rdata = 64'hA0 + 64'(b); m_rresp = (b == 1) ? 2'b10 : 2'b00; m_rlast = (b == 2);
      #1;
      tests++; if (s0_rvalid !== 1'b1 || s1_rvalid !== 1'b0 || m_rready !== 1'b1) begin fails++; $display("FAIL rd_r_route%0d got=%0h/%0h/%0h exp=1/0/1", b, s0_rvalid, s1_rvalid, m_rready); end
      tests++; if (s0_rdata !== 64'hA0 + 64'(b) || s0_rresp !== ((b == 1) ? 2'b10 : 2'b00) || s0_rid !== 5'h01) begin fails++; $display("FAIL rd_r_data%0d got=%h/%0h/%0h", b, s0_rdata, s0_rresp, s0_rid); end
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; s0_rready = 1'b0; #1;
    tests++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL rd_turnaround got=%0h exp=0", m_arvalid); end
    tick(); #1;
    tests++; if (m_arvalid !== 1'b1 || m_arid !== 5'h02 || m_araddr !== 64'h0000_0000_0000_2000) begin fails++; $display("FAIL rd_grant1 got=%0h/%0h/%h exp=1/2/0000000000002000", m_arvalid, m_arid, m_araddr); end
    tests++; if (s1_arready !== 1'b1 || s0_arready !== 1'b0) begin fails++; $display("FAIL rd_arready1 got=%0h/%0h exp=1/0", s1_arready, s0_arready); end
    tick();
    s1_arvalid = 1'b0; s1_rready = 1'b1; m_rvalid = 1'b1; m_rid = 5'h02; m_rdata = 64'hB0; m_rlast = 1'b1; #1;
    tests++; if (s1_rvalid !== 1'b1 || s0_rvalid !== 1'b0 || s1_rdata !== 64'hB0 || s1_rlast !== 1'b1) begin fails++; $display("FAIL rd_r1 got=%0h/%0h/%h/%0h exp=1/0/b0/1", s1_rvalid, s0_rvalid, s1_rdata, s1_rlast); end
    tick(); clear_inputs();
  endtask

  task test_concurrent;
    s0_awvalid = 1'b1; s0_awid = 5'h0A; s0_awaddr = 64'h0000_0001_0000_0040; s0_awlen = 8'd0;
    s0_wvalid = 1'b1; s0_wdata = 64'hCAFE; s0_wlast = 1'b1; s0_wstrb = 8'h0F;
    s1_arvalid = 1'b1; s1_arid = 5'h0B; s1_araddr = 64'hFFFF_0000_0000_0080;
    m_awready = 1'b1; m_arready = 1'b1; m_wready = 1'b1;
    tick(); #1;
    tests++; if (m_awvalid !== 1'b1 || m_arvalid !== 1'b1) begin fails++; $display("FAIL cc_both_valid got=%0h/%0h exp=1/1", m_awvalid, m_arvalid); end
    tests++; if (m_awid !== 5'h0A || m_arid !== 5'h0B || m_araddr !== 64'h0000_0000_0000_0080) begin fails++; $display("FAIL cc_ids got=%0h/%0h/%h exp=a/b/80", m_awid, m_arid, m_araddr); end
    tests++; if (m_awaddr !== 64'h0000_0001_0000_0040) begin fails++; $display("FAIL cc_m0_mask got=%h exp=0000000100000040", m_awaddr); end
    tick();
    s0_awvalid = 1'b0; s1_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rid = 5'h0B; m_rdata = 64'hBEEF; m_rlast = 1'b1; s1_rready = 1'b1; s0_rready = 1'b1; #1;
    tests++; if (m_wvalid !== 1'b1 || m_wdata !== 64'hCAFE || m_wstrb !== 8'h0F || s0_wready !== 1'b1) begin fails++; $display("FAIL cc_w got=%0h/%h/%h/%0h exp=1/cafe/0f/1", m_wvalid, m_wdata, m_wstrb, s0_wready); end
    tests++; if (s1_rvalid !== 1'b1 || s0_rvalid !== 1'b0 || s1_rdata !== 64'hBEEF) begin fails++; $display("FAIL cc_r got=%0h/%0h/%h exp=1/0/beef", s1_rvalid, s0_rvalid, s1_rdata); end
    tick();
    s0_wvalid = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    m_bvalid = 1'b1; m_bid = 5'h0A; m_bresp = 2'b11; s0_bready = 1'b1; s1_bready = 1'b1; #1;
    tests++; if (s0_bvalid !== 1'b1 || s1_bvalid !== 1'b0 || s0_bresp !== 2'b11 || s0_bid !== 5'h0A) begin fails++; $display("FAIL cc_b got=%0h/%0h/%0h/%0h exp=1/0/3/a", s0_bvalid, s1_bvalid, s0_bresp, s0_bid); end
    tests++; if (s1_rvalid !== 1'b0 || m_rready !== 1'b0) begin fails++; $display("FAIL cc_r_done got=%0h/%0h exp=0/0", s1_rvalid, m_rready); end
    tick(); clear_inputs();
  endtask

  task test_wstall;
    int bt, ncyc;
    logic exp_rdy;
    s0_awvalid = 1'b1; s0_awid = 5'h04; s0_awaddr = 64'h100; s0_awlen = 8'd3; m_awready = 1'b1;
    tick(); #1;
    tests++; if (s0_awready !== 1'b1) begin fails++; $display("FAIL st_awready got=%0h exp=1", s0_awready); end
    tick();
    s0_awvalid = 1'b0; m_awready = 1'b0; s0_wvalid = 1'b1; s1_wvalid = 1'b1;
    bt = 0; ncyc = 0;
    while (bt < 4 && ncyc < 20) begin
      exp_rdy = !(ncyc >= 1 && ncyc <= 5);
      m_wready = exp_rdy; s0_wdata = 64'hE0 + 64'(bt); s0_wlast = (bt == 3); #1;
      tests++; if (m_wdata !== 64'hE0 + 64'(bt) || m_wvalid !== 1'b1) begin fails++; $display("FAIL st_wdata c%0d got=%h/%0h exp=%h/1", ncyc, m_wdata, m_wvalid, 64'hE0 + 64'(bt)); end
      tests++; if (s0_wready !== exp_rdy || s1_wready !== 1'b0) begin fails++; $display("FAIL st_wready c%0d got=%0h/%0h exp=%0h/0", ncyc, s0_wready, s1_wready, exp_rdy); end
      if (exp_rdy) bt++;
      ncyc++;
      tick();
    end
    tests++; if (ncyc !== 9) begin fails++; $display("FAIL st_cycles got=%0d exp=9", ncyc); end
    s0_wdata = 64'hE4; s0_wlast = 1'b0; m_wready = 1'b1;
    m_bvalid = 1'b1; m_bid = 5'h04; s0_bready = 1'b1; #1;
    tests++; if (m_wvalid !== 1'b0 || s0_bvalid !== 1'b1 || m_bready !== 1'b1) begin fails++; $display("FAIL st_resp got=%0h/%0h/%0h exp=0/1/1", m_wvalid, s0_bvalid, m_bready); end
    tick(); clear_inputs();
  endtask

  task test_rst_mid;
    s0_awvalid = 1'b1; s0_awid = 5'h07; s0_awlen = 8'd1; m_awready = 1'b1; m_wready = 1'b1;
    tick(); tick();
    s0_awvalid = 1'b0; s0_wvalid = 1'b1; s0_wdata = 64'h77; #1;
    tests++; if (s0_wready !== 1'b1) begin fails++; $display("FAIL rm_in_data got=%0h exp=1", s0_wready); end
    tick();
    rst = 1'b1; s0_awvalid = 1'b1; s1_awvalid = 1'b1; s0_awid = 5'h11; s1_awid = 5'h12; m_bvalid = 1'b1; s0_bready = 1'b1;
    tick(); #1;
    tests++; if (m_wvalid !== 1'b0 || s0_wready !== 1'b0 || m_awvalid !== 1'b0) begin fails++; $display("FAIL rm_drop got=%0h/%0h/%0h exp=0/0/0", m_wvalid, s0_wready, m_awvalid); end
    tests++; if (s0_awready !== 1'b0 || m_bready !== 1'b0 || s0_bvalid !== 1'b0) begin fails++; $display("FAIL rm_drop2 got=%0h/%0h/%0h exp=0/0/0", s0_awready, m_bready, s0_bvalid); end
    rst = 1'b0; m_bvalid = 1'b0; s0_wvalid = 1'b0;
    tick(); #1;
    tests++; if (m_awvalid !== 1'b1 || m_awid !== 5'h11) begin fails++; $display("FAIL rm_tie_s0 got=%0h/%0h exp=1/11", m_awvalid, m_awid); end
    rst = 1'b1; tick();
    rst = 1'b0; s0_awvalid = 1'b0;
    tick(); #1;
    tests++; if (m_awvalid !== 1'b1 || m_awid !== 5'h12 || s1_awready !== 1'b1) begin fails++; $display("FAIL rm_s1_alone got=%0h/%0h/%0h exp=1/12/1", m_awvalid, m_awid, s1_awready); end
    clear_inputs(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs(); rst = 1'b1;
    test_reset();
    test_write_m1();
    test_read_rr();
    test_concurrent();
    test_wstall();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
